// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback result pipe.
// Optional load-data extension is selected with the WB_LOAD_EXT_EN macro.
package wb_pkg;

    // Result source selector.
    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_PCT = 2'd3
    } res_sel_e;

    // Load funct3 encodings.
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    // Default-width layout of one buffered writeback entry. The pipe builds
    // an identically ordered entry type from its own DATA_W/RD_W parameters.
    localparam int WB_DATA_W = 32;
    localparam int WB_RD_W   = 5;

    typedef struct packed {
        logic [WB_DATA_W-1:0] data;
        logic [WB_RD_W-1:0]   rd;
        logic                 reg_write;
    } wb_entry_t;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load-data extender: LB/LH sign-extend, LBU/LHU zero-extend,
// LW and any unlisted funct3 pass the raw word. Only used when WB_LOAD_EXT_EN
// is defined.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        funct3_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] data_o
);

    // Pick the extension according to the load type.
    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            LD_LB:   data_o = {{(DATA_W-8){rdata_i[7]}}, rdata_i[7:0]};
            LD_LH:   data_o = {{(DATA_W-16){rdata_i[15]}}, rdata_i[15:0]};
            LD_LBU:  data_o = {{(DATA_W-8){1'b0}}, rdata_i[7:0]};
            LD_LHU:  data_o = {{(DATA_W-16){1'b0}}, rdata_i[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_result_pipe.sv
// Registered MEM/WB result stage: selects one of four result sources,
// optionally extends load data (macro WB_LOAD_EXT_EN), zero-extends PC values
// and presents the result through a two-entry skid buffer.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. in_valid/in_ready carry results in from MEM, out_valid/
// out_ready carry them out to the register file. out_valid and the wb_*
// fields hold stable while out_valid & !out_ready. in_ready comes from a flop
// and never depends combinationally on out_ready.
module wb_result_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        res_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [2:0]        ld_funct3,
    input  logic [PC_W-1:0]   pc_plus4,
    input  logic [PC_W-1:0]   pc_target,
    input  logic [RD_W-1:0]   rd,
    input  logic              reg_write,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_we,
    output logic [1:0]        dbg_state
);

    if (PC_W > DATA_W) begin : g_bad_pc_w
        $error("wb_result_pipe: PC_W must not exceed DATA_W");
    end

    // Same field order as wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
        logic              reg_write;
    } entry_t;

    logic [DATA_W-1:0] mem_ext;
    logic [DATA_W-1:0] result;
    entry_t            in_entry;

    skid_state_e state_q, state_d;
    entry_t      head_q, head_d;
    entry_t      skid_q, skid_d;
    logic        in_ready_q;
    logic        accept;
    logic        consume;

`ifdef WB_LOAD_EXT_EN
    wb_load_ext #(
        .DATA_W (DATA_W)
    ) u_load_ext (
        .funct3_i (ld_funct3),
        .rdata_i  (mem_rdata),
        .data_o   (mem_ext)
    );
`else
    // Extension already done in the LSU; funct3 is intentionally ignored.
    logic unused_ld_funct3;
    assign unused_ld_funct3 = ^ld_funct3;
    assign mem_ext          = mem_rdata;
`endif

    // Form the candidate result from the selected source.
    always_comb begin
        result = alu_result;
        case (res_sel_e'(res_sel))
            RES_ALU: result = alu_result;
            RES_MEM: result = mem_ext;
            RES_PC4: result = DATA_W'(pc_plus4);
            RES_PCT: result = DATA_W'(pc_target);
            default: result = alu_result;
        endcase
    end

    assign in_entry = '{data: result, rd: rd, reg_write: reg_write};

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign consume   = out_valid & out_ready;

    // Next occupancy and entry contents; flush empties the buffer and drops
    // any same-cycle input.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    head_d  = in_entry;
                end
            end
            ST_ONE: begin
                if (consume && accept) begin
                    head_d = in_entry;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end else if (accept) begin
                    state_d = ST_TWO;
                    skid_d  = in_entry;
                end
            end
            ST_TWO: begin
                if (consume) begin
                    state_d = ST_ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            head_d  = head_q;
            skid_d  = skid_q;
        end
    end

    // State, storage and registered ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    assign wb_data   = head_q.data;
    assign wb_rd     = head_q.rd;
    assign wb_we     = out_valid & head_q.reg_write & (head_q.rd != '0);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_result_pipe.sv
// Directed bench for wb_result_pipe: a table of single-result vectors applied
// back-to-back, plus hand-written skid, flush, x0 and reset sequences.
module tb_wb_result_pipe;
    import wb_pkg::*;

`ifdef WB_LOAD_EXT_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  res_sel = 2'd0;
    logic [31:0] alu_result = '0;
    logic [31:0] mem_rdata = '0;
    logic [2:0]  ld_funct3 = '0;
    logic [8:0]  pc_plus4 = '0;
    logic [8:0]  pc_target = '0;
    logic [4:0]  rd = '0;
    logic        reg_write = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [1:0]  dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    wb_result_pipe #(.DATA_W(32), .PC_W(9), .RD_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .res_sel    (res_sel),
        .alu_result (alu_result),
        .mem_rdata  (mem_rdata),
        .ld_funct3  (ld_funct3),
        .pc_plus4   (pc_plus4),
        .pc_target  (pc_target),
        .rd         (rd),
        .reg_write  (reg_write),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_we      (wb_we),
        .dbg_state  (dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [2:0]  f3;
        logic [8:0]  pc4;
        logic [8:0]  pct;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] exp_ext;
        logic [31:0] exp_raw;
        logic        exp_we;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one ALU-sourced result on the input side.
    task automatic drive_alu(input logic [31:0] data, input logic [4:0] dst);
        in_valid   = 1'b1;
        res_sel    = 2'd0;
        alu_result = data;
        rd         = dst;
        reg_write  = 1'b1;
    endtask

    initial begin
        bit c_taken;

        vecs[0]  = '{"alu",      2'd0, 32'h1234_5678, 32'h0,         3'b000, 9'h0,   9'h0,   5'd3,  1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1};
        vecs[1]  = '{"pc4",      2'd2, 32'h0,         32'h0,         3'b000, 9'h1F4, 9'h0,   5'd1,  1'b1, 32'h0000_01F4, 32'h0000_01F4, 1'b1};
        vecs[2]  = '{"pct_nowe", 2'd3, 32'h0,         32'h0,         3'b000, 9'h0,   9'h1FF, 5'd31, 1'b0, 32'h0000_01FF, 32'h0000_01FF, 1'b0};
        vecs[3]  = '{"lb_neg",   2'd1, 32'h0,         32'h0000_0080, 3'b000, 9'h0,   9'h0,   5'd4,  1'b1, 32'hFFFF_FF80, 32'h0000_0080, 1'b1};
        vecs[4]  = '{"lh_neg",   2'd1, 32'h0,         32'h1234_8001, 3'b001, 9'h0,   9'h0,   5'd5,  1'b1, 32'hFFFF_8001, 32'h1234_8001, 1'b1};
        vecs[5]  = '{"lw",       2'd1, 32'h0,         32'h8765_4321, 3'b010, 9'h0,   9'h0,   5'd6,  1'b1, 32'h8765_4321, 32'h8765_4321, 1'b1};
        vecs[6]  = '{"lbu",      2'd1, 32'h0,         32'hFFFF_FF80, 3'b100, 9'h0,   9'h0,   5'd7,  1'b1, 32'h0000_0080, 32'hFFFF_FF80, 1'b1};
        vecs[7]  = '{"lhu",      2'd1, 32'h0,         32'hABCD_F00D, 3'b101, 9'h0,   9'h0,   5'd8,  1'b1, 32'h0000_F00D, 32'hABCD_F00D, 1'b1};
        vecs[8]  = '{"f3_011",   2'd1, 32'h0,         32'hCAFE_BABE, 3'b011, 9'h0,   9'h0,   5'd9,  1'b1, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b1};
        vecs[9]  = '{"x0_write", 2'd0, 32'hDEAD_BEEF, 32'h0,         3'b000, 9'h0,   9'h0,   5'd0,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[10] = '{"lb_pos",   2'd1, 32'h0,         32'h0000_007F, 3'b000, 9'h0,   9'h0,   5'd10, 1'b1, 32'h0000_007F, 32'h0000_007F, 1'b1};
        vecs[11] = '{"lh_pos",   2'd1, 32'h0,         32'h0000_7FFF, 3'b001, 9'h0,   9'h0,   5'd11, 1'b1, 32'h0000_7FFF, 32'h0000_7FFF, 1'b1};

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_wb_data",   wb_data,        32'd0);
        check("rst_wb_rd",     32'(wb_rd),     32'd0);
        check("rst_wb_we",     32'(wb_we),     32'd0);
        reset = 1'b0;
        tick();

        // Table vectors, one per cycle with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid   = 1'b1;
            res_sel    = vecs[i].sel;
            alu_result = vecs[i].alu;
            mem_rdata  = vecs[i].mem;
            ld_funct3  = vecs[i].f3;
            pc_plus4   = vecs[i].pc4;
            pc_target  = vecs[i].pct;
            rd         = vecs[i].rd;
            reg_write  = vecs[i].rw;
            tick();
            check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            check({vecs[i].name, "_data"},  wb_data, EXT_EN ? vecs[i].exp_ext : vecs[i].exp_raw);
            check({vecs[i].name, "_rd"},    32'(wb_rd), 32'(vecs[i].rd));
            check({vecs[i].name, "_we"},    32'(wb_we), 32'(vecs[i].exp_we));
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Skid: A, B accepted with out_ready low, C held off
        out_ready = 1'b0;
        drive_alu(32'hAAAA_0001, 5'd1);
        exp_q.push_back(32'hAAAA_0001);
        tick();
        check("skid_rdy_after_a", 32'(in_ready), 32'd1);
        drive_alu(32'hBBBB_0002, 5'd2);
        exp_q.push_back(32'hBBBB_0002);
        tick();
        check("skid_rdy_after_b", 32'(in_ready), 32'd0);
        check("skid_hold_a",      wb_data, 32'hAAAA_0001);
        drive_alu(32'hCCCC_0003, 5'd3);
        exp_q.push_back(32'hCCCC_0003);
        tick();
        check("skid_c_held",      32'(in_ready), 32'd0);
        check("skid_state_two",   32'(dbg_state), 32'(ST_TWO));
        check("skid_still_a",     wb_data, 32'hAAAA_0001);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("skid_order_valid", 32'(out_valid), 32'd1);
            check("skid_order_data", wb_data, exp_q.pop_front());
            c_taken = in_valid & in_ready;
            tick();
            if (c_taken) in_valid = 1'b0;
        end
        check("skid_drained", 32'(out_valid), 32'd0);
        check("skid_q_empty", 32'(exp_q.size()), 32'd0);

        // Flush in state TWO with a same-cycle input and consume
        out_ready = 1'b0;
        drive_alu(32'hDDDD_0004, 5'd4);
        tick();
        drive_alu(32'hEEEE_0005, 5'd5);
        tick();
        check("flush_pre_two", 32'(dbg_state), 32'(ST_TWO));
        drive_alu(32'hFFFF_0006, 5'd6);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready),  32'd1);
        tick();
        check("flush_no_f",  32'(out_valid), 32'd0);

        // x0 write: handshaken but not enabled
        drive_alu(32'hDEAD_BEEF, 5'd0);
        tick();
        in_valid = 1'b0;
        check("x0_valid", 32'(out_valid), 32'd1);
        check("x0_we",    32'(wb_we),     32'd0);
        check("x0_data",  wb_data,        32'hDEAD_BEEF);
        tick();

        // Reset while holding two entries
        out_ready = 1'b0;
        drive_alu(32'h1111_0007, 5'd7);
        tick();
        drive_alu(32'h2222_0008, 5'd8);
        tick();
        in_valid = 1'b0;
        check("rst2_pre_two", 32'(dbg_state), 32'(ST_TWO));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_valid",   32'(out_valid), 32'd0);
        check("rst2_data",    wb_data,        32'd0);
        check("rst2_ready",   32'(in_ready),  32'd1);
        check("rst2_we",      32'(wb_we),     32'd0);
        tick();
        check("rst2_stay_empty", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_result_pipe.md
Name: wb_result_pipe

Overview:
- Parametrised successor to the writeback result selector, built as a registered MEM/WB stage.
- Selects one of four result sources, applies load-data extension, and zero-extends PC values of PC_W bits to DATA_W.
- Drives the register-file write port through a 2-entry skid buffer with a valid/ready handshake, so downstream stalls do not create a combinational ready path back into MEM.

Parameters:
- DATA_W, 32, datapath and register width.
- PC_W, 9, width of the PC fields; zero-extended to DATA_W. Must satisfy PC_W <= DATA_W.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  MEM stage presents a result.
- in_ready  out  1  stage can accept; registered, not derived from out_ready.
- res_sel  in  2  result source: 0 ALU, 1 MEM, 2 PC+4, 3 PC target.
- alu_result  in  DATA_W  ALU output.
- mem_rdata  in  DATA_W  raw load word, little-endian, already byte-aligned to bit 0.
- ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- pc_plus4  in  PC_W  return address.
- pc_target  in  PC_W  branch/jump target.
- rd  in  RD_W  destination register.
- reg_write  in  1  instruction writes rd.
- flush  in  1  discard all buffered results.
- out_valid  out  1  wb_* fields are valid.
- out_ready  in  1  consumer accepts.
- wb_data  out  DATA_W  selected, extended result.
- wb_rd  out  RD_W  destination register.
- wb_we  out  1  out_valid & reg_write & (rd != 0).

Behaviour:
- Result formation is combinational at the input and is captured on acceptance, where acceptance = in_valid & in_ready.
  - PC sources: {(DATA_W-PC_W)'0, pc}.
  - MEM source: extended per ld_funct3. Unlisted funct3 codes pass the word unchanged.
- Storage is two entries: head drives the outputs, skid holds overflow. States are EMPTY, ONE, TWO.
  - EMPTY: on acceptance -> ONE, with head loaded.
  - ONE, head consumed and new accept -> ONE, head replaced.
  - ONE, head consumed only -> EMPTY.
  - ONE, accept only -> TWO, skid loaded.
  - TWO: in_ready=0. On consume, skid moves to head -> ONE.
- in_ready = (state != TWO), registered.
- Latency: one cycle from acceptance to out_valid. Throughput is 1/cycle while out_ready=1.
- out_valid = (state != EMPTY). Outputs hold stable while out_valid & !out_ready.
- Flush: the next state is EMPTY regardless of other inputs. Flush wins over a same-cycle acceptance (input dropped) and over a same-cycle consume.
- Reset: state EMPTY; out_valid=0, in_ready=1 after the reset edge; wb_data=0, wb_rd=0, wb_we=0. Reset mid-transfer discards all entries.
- Writes to x0 are buffered and handshaken normally, but wb_we is held at 0.

Optional Feature:
- WB_LOAD_EXT_EN defined: LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW passes the full word.
- Not defined: mem_rdata passes unmodified and ld_funct3 is ignored (extension is done in the LSU).

Decomposition:
- Package wb_pkg:
  - res_sel_e enum (RES_ALU, RES_MEM, RES_PC4, RES_PCT).
  - LD_* funct3 localparams.
  - wb_entry_t struct (data, rd, reg_write).
  - skid state enum.
- Sub-module wb_load_ext: combinational extender, parameter DATA_W, instantiated only under WB_LOAD_EXT_EN.

Test Plan:
- res_sel=2, pc_plus4=9'h1F4, out_ready=1 -> one cycle later wb_data=32'h0000_01F4, out_valid=1.
- res_sel=1, ld_funct3=000, mem_rdata=32'h0000_0080 -> wb_data=32'hFFFF_FF80 with the macro defined; 32'h0000_0080 without it.
- out_ready=0, feed 3 results A,B,C back-to-back -> A and B accepted; in_ready falls after B; C held off. Then out_ready=1 -> A, B, C appear in order with no loss or duplication.
- flush=1 asserted together with in_valid while in state TWO -> next cycle out_valid=0 and in_ready=1; the flushed-cycle input never appears.
- rd=0, reg_write=1, alu_result=32'hDEAD_BEEF -> out_valid=1, wb_we=0.
- reset asserted while in state TWO -> after the edge out_valid=0, wb_data=0, in_ready=1.
